// File: rtl/ysyx_24100027_lsu.sv
// ysyx_24100027_lsu: single-outstanding load/store unit with a fixed-latency memory port.
// Request fields are captured on accept; the FSM walks IDLE -> ISSUE -> WAIT -> RESP.
module ysyx_24100027_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [2:0]          req_memop,
  input  logic                req_wen,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t r_state, w_nxt;
  logic r_req_ready, r_resp_valid, r_resp_err, r_mem_en, r_mem_we, r_wen, r_sgn;
  logic [1:0] r_sz;
  logic [OW-1:0] r_off;
  logic [3:0] r_cnt;
  logic [DATA_W-1:0] r_resp_rdata, r_mem_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [NB-1:0] r_mem_wmask;
  logic w_acc, w_ill, w_mis, w_bad;
  logic [1:0] w_sz;
  logic [OW-1:0] w_off;
  logic [7:0] w_sm;
  logic [63:0] w_sh;
  logic [DATA_W-1:0] w_ext;
  assign w_acc = req_valid & r_req_ready;
  assign w_sz  = req_memop[1:0];
  assign w_off = req_addr[OW-1:0];
  // Doubles and unsigned words only exist on a 64-bit data path; stores may use 110 as a word.
  assign w_ill = req_memop == 3'b111 ||
                 (DATA_W == 32 && (w_sz == 2'd3 || (!req_wen && req_memop == 3'b110)));
  assign w_mis = w_sz == 2'd1 ? req_addr[0] : w_sz == 2'd2 ? |req_addr[1:0] :
                 w_sz == 2'd3 ? |req_addr[2:0] : 1'b0;
  assign w_bad = w_ill | w_mis;
  assign w_sm  = w_sz == 2'd0 ? 8'h01 : w_sz == 2'd1 ? 8'h03 : w_sz == 2'd2 ? 8'h0F : 8'hFF;
  assign w_sh  = 64'(mem_rdata) >> {r_off, 3'b000};
  assign w_ext = DATA_W'(r_sz == 2'd0 ? {{56{r_sgn & w_sh[7]}}, w_sh[7:0]} :
                         r_sz == 2'd1 ? {{48{r_sgn & w_sh[15]}}, w_sh[15:0]} :
                         r_sz == 2'd2 ? {{32{r_sgn & w_sh[31]}}, w_sh[31:0]} : w_sh);
  always_comb begin
    w_nxt = r_state;
    w_nxt = r_state == IDLE  ? (w_acc ? (w_bad ? RESP : ISSUE) : IDLE) :
            r_state == ISSUE ? WAIT :
            r_state == WAIT  ? (r_cnt == 4'd0 ? RESP : WAIT) :
                               (resp_ready ? IDLE : RESP);
  end
  // Every output is a flop loaded from the next state, so outputs track the state with no lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wmask  <= '0;
      r_wen        <= 1'b0;
      r_sgn        <= 1'b0;
      r_sz         <= '0;
      r_off        <= '0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_nxt;
      r_req_ready  <= w_nxt == IDLE;
      r_resp_valid <= w_nxt == RESP;
      r_mem_en     <= w_nxt == ISSUE;
      r_mem_we     <= w_nxt == ISSUE && req_wen;
      if (w_acc) begin
        r_wen        <= req_wen;
        r_sgn        <= !req_memop[2];
        r_sz         <= w_sz;
        r_off        <= w_off;
        r_cnt        <= 4'(LATENCY - 1);
        r_mem_addr   <= {req_addr[ADDR_W-1:OW], OW'(0)};
        r_mem_wdata  <= req_wdata << {w_off, 3'b000};
        r_mem_wmask  <= req_wen && !w_bad ? NB'({8'h00, w_sm} << w_off) : '0;
        r_resp_err   <= w_bad;
        r_resp_rdata <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd0) r_resp_rdata <= r_wen ? '0 : w_ext;
      end
    end
  end
  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wmask  = r_mem_wmask;
endmodule

// File: doc/ysyx_24100027_lsu.md
YSYX_24100027_LSU -- requirements
Module: ysyx_24100027_lsu

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning the data-path width; the only legal values are 32 and 64.
REQ-002 The module SHALL have parameter ADDR_W, default 32, meaning the byte-address width.
REQ-003 The module SHALL have parameter LATENCY, default 1, meaning the fixed number of cycles from mem_en to valid mem_rdata; the legal range is 1..15.
REQ-004 The module SHALL have one clock and an asynchronous, active-high reset, with ports in this order:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
REQ-005 The module SHALL have the following request and response ports:
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- req_memop  in  3  access size and sign
- req_wen  in  1  1 = store, 0 = load
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  DATA_W  load result, extended
- resp_err  out  1  misaligned or illegal access
REQ-006 The module SHALL have the following memory-side ports:
- mem_en  out  1  one-cycle access strobe
- mem_we  out  1  write strobe qualifier
- mem_addr  out  ADDR_W  word address, low log2(DATA_W/8) bits forced to 0
- mem_wdata  out  DATA_W  lane-shifted store data
- mem_wmask  out  DATA_W/8  byte-enable mask
- mem_rdata  in  DATA_W  read data, valid LATENCY cycles after mem_en

Function
REQ-007 req_memop SHALL be decoded as:
- 000: byte signed
- 001: half signed
- 010: word signed
- 011: double (DATA_W=64 only)
- 100: byte unsigned
- 101: half unsigned
- 110: word unsigned (DATA_W=64 only)
- 111: always illegal
REQ-008 For stores, the sign bit req_memop[2] SHALL be ignored; 100, 101 and 110 SHALL be treated as 000, 001 and 010 respectively.
REQ-009 The FSM SHALL have four states, IDLE, ISSUE, WAIT and RESP, and SHALL reset to IDLE.
REQ-010 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-011 On accept, all request fields SHALL be captured; an illegal or misaligned request SHALL go to RESP, and any other request SHALL go to ISSUE.
REQ-012 A request SHALL be misaligned when the address offset is not a multiple of the access size (half: addr[0]; word: addr[1:0]; double: addr[2:0]).
REQ-013 In ISSUE, mem_en SHALL be 1 for exactly one cycle, mem_we SHALL equal the captured req_wen, and the FSM SHALL then move to WAIT; mem_en SHALL be 0 in every other state.
REQ-014 mem_wmask SHALL be the size mask (1, 3, 0xF or 0xFF) shifted left by the byte offset.
REQ-015 mem_wdata SHALL be req_wdata shifted left by 8 x the byte offset.
REQ-016 For loads, mem_wmask SHALL be 0.
REQ-017 A 4-bit counter SHALL count LATENCY cycles after ISSUE; on its final cycle mem_rdata SHALL be sampled and the FSM SHALL move to RESP.
REQ-018 Load result: mem_rdata SHALL be shifted right by 8 x the byte offset, truncated to the access size, then sign-extended (signed ops) or zero-extended (unsigned ops) to DATA_W.
REQ-019 For stores, resp_rdata SHALL be 0.
REQ-020 For error responses, resp_rdata SHALL be 0, resp_err SHALL be 1, and no mem_en pulse SHALL be issued.
REQ-021 In RESP, resp_valid SHALL be 1, and resp_rdata and resp_err SHALL be held stable until resp_ready is 1; the FSM SHALL then return to IDLE on that edge.
REQ-022 Latency, for a request accepted at edge T:
- mem_en high during cycle T+1
- resp_valid first high after edge T+2+LATENCY
- an error request raises resp_valid after edge T+1
REQ-023 A new request SHALL NOT be accepted in the cycle resp_valid and resp_ready are both 1; back-to-back throughput SHALL be one access per LATENCY+3 cycles.
REQ-024 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-025 While rst is 1, the module SHALL drive the following values, independent of clk:
- req_ready=0
- resp_valid=0
- resp_rdata=0
- resp_err=0
- mem_en=0
- mem_we=0
- mem_addr=0
- mem_wdata=0
- mem_wmask=0
REQ-026 On the first edge after rst falls, the FSM SHALL be in IDLE and req_ready SHALL be 1.
REQ-027 Reset asserted during ISSUE, WAIT or RESP SHALL abort the access immediately: no response is produced, and a pending mem_en SHALL be dropped the same cycle.

Verification
REQ-028 Load, LATENCY=1, DATA_W=32: addr=0x8000_0003, memop=000, mem_rdata=0x80FF_FF12 -> mem_addr=0x8000_0000, resp_rdata=0xFFFF_FF80, resp_err=0, resp_valid 3 cycles after accept.
REQ-029 Store half: addr=0x102, memop=001, wdata=0x0000_BEEF -> mem_wmask=0xC, mem_wdata=0xBEEF_0000, mem_we=1, a single mem_en pulse, resp_rdata=0.
REQ-030 Misaligned word load: addr=0x101, memop=010 -> no mem_en pulse, resp_err=1, resp_valid after 1 cycle; memop=111 gives the same response.
REQ-031 Backpressure, LATENCY=4: resp_ready held 0 for 5 cycles -> resp_valid stays 1, resp_rdata stable, req_ready stays 0 until the handshake edge.
REQ-032 DATA_W=64: addr=0x8, memop=011, mem_rdata=0x1122_3344_5566_7788 -> resp_rdata unchanged; memop=110 at addr 0xC with mem_rdata=0x8000_0000_0000_0000 -> resp_rdata=0x0000_0000_8000_0000.
REQ-033 Reset mid-WAIT, LATENCY=8: rst pulsed at counter=3 -> resp_valid never rises and all outputs are 0 asynchronously; the next request completes normally.
